fb_bus_writer: RTL and testbench

FB_BUS_WRITER -- requirements
Module: fb_bus_writer

---
 rtl/fb_bus_writer.sv | 177 +++++++++++++++++
 tb/tb_fb_bus_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_bus_writer.sv
// Framebuffer writer: converts RUN/CFG/FLIP commands into emulated 6502 write cycles of 2 clocks each.
// One command at a time; CmdReady is high only while idle, so senders wait for the whole command to finish.
module fb_bus_writer #(
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [1:0]  CmdOp,
  input  logic [7:0]  CmdX,
  input  logic [6:0]  CmdY,
  input  logic [7:0]  CmdLen,
  input  logic [7:0]  CmdData,
  input  logic        VBlank,
  output logic [15:0] AddrPhys,
  output logic [7:0]  DataOut,
  output logic        CpuWe_n,
  output logic        CpuClock_n,
  output logic        Busy,
  output logic        Clipped,
  output logic [7:0]  CfgShadow
);

  localparam logic [8:0]  XMAX9    = 9'(XMAX);
  localparam logic [7:0]  XMAX8    = 8'(XMAX);
  localparam logic [6:0]  YMAX7    = 7'(YMAX);
  localparam logic [15:0] REG_ADDR = 16'h40A0;
  localparam logic [1:0]  OP_RUN   = 2'd0;
  localparam logic [1:0]  OP_CFG   = 2'd1;
  localparam logic [1:0]  OP_FLIP  = 2'd2;

  typedef enum logic [2:0] {
    IDLE, BANK_A, BANK_B, PIX_A, PIX_B, WAITVB, REG_A, REG_B
  } state_t;

  state_t      state;
  logic [7:0]  cur_x;
  logic [7:0]  end_x;
  logic [5:0]  row;
  logic [7:0]  pix_dat;
  logic        clip_pend;
  logic        vb_prev;

  // Sum kept at 9 bits so X+Len past 255 still registers as a clip.
  logic [8:0]  run_end;
  logic        run_clip;
  logic        run_drop;
  assign run_end  = {1'b0, CmdX} + {1'b0, CmdLen};
  assign run_clip = run_end > XMAX9;
  assign run_drop = (CmdY > YMAX7) || (CmdX > XMAX8);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      CmdReady   <= 1'b0;
      AddrPhys   <= '0;
      DataOut    <= '0;
      CpuWe_n    <= 1'b1;
      CpuClock_n <= 1'b1;
      Busy       <= 1'b0;
      Clipped    <= 1'b0;
      CfgShadow  <= '0;
      cur_x      <= '0;
      end_x      <= '0;
      row        <= '0;
      pix_dat    <= '0;
      clip_pend  <= 1'b0;
      vb_prev    <= 1'b0;
    end else begin
      vb_prev <= VBlank;
      Clipped <= 1'b0;
      case (state)
        IDLE: begin
          CmdReady <= 1'b1;
          if (CmdValid && CmdReady) begin
            case (CmdOp)
              OP_RUN: begin
                if (run_drop) begin
                  Clipped <= 1'b1;
                end else begin
                  row        <= CmdY[5:0];
                  cur_x      <= CmdX;
                  pix_dat    <= CmdData;
                  clip_pend  <= run_clip;
                  end_x      <= run_clip ? XMAX8 : run_end[7:0];
                  CmdReady   <= 1'b0;
                  Busy       <= 1'b1;
                  CpuWe_n    <= 1'b0;
                  CpuClock_n <= 1'b1;
                  // Bank bit lives in the config register, so switch it before any pixel lands.
                  if (CmdY[6] != CfgShadow[1]) begin
                    state    <= BANK_A;
                    AddrPhys <= REG_ADDR;
                    DataOut  <= {CfgShadow[7:2], CmdY[6], CfgShadow[0]};
                  end else begin
                    state    <= PIX_A;
                    AddrPhys <= {2'b01, CmdY[5:0], CmdX};
                    DataOut  <= CmdData;
                  end
                end
              end
              OP_CFG: begin
                state      <= REG_A;
                CmdReady   <= 1'b0;
                Busy       <= 1'b1;
                AddrPhys   <= REG_ADDR;
                DataOut    <= CmdData;
                CpuWe_n    <= 1'b0;
                CpuClock_n <= 1'b1;
              end
              OP_FLIP: begin
                state    <= WAITVB;
                CmdReady <= 1'b0;
                Busy     <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        BANK_A: begin
          state      <= BANK_B;
          CpuClock_n <= 1'b0;
        end
        BANK_B: begin
          CfgShadow  <= DataOut;
          state      <= PIX_A;
          AddrPhys   <= {2'b01, row, cur_x};
          DataOut    <= pix_dat;
          CpuClock_n <= 1'b1;
        end
        PIX_A: begin
          state      <= PIX_B;
          CpuClock_n <= 1'b0;
        end
        PIX_B: begin
          CpuClock_n <= 1'b1;
          if (cur_x == end_x) begin
            state    <= IDLE;
            CpuWe_n  <= 1'b1;
            Busy     <= 1'b0;
            CmdReady <= 1'b1;
            Clipped  <= clip_pend;
          end else begin
            state    <= PIX_A;
            cur_x    <= cur_x + 8'd1;
            AddrPhys <= {2'b01, row, cur_x + 8'd1};
          end
        end
        WAITVB: begin
          if (VBlank && !vb_prev) begin
            state      <= REG_A;
            AddrPhys   <= REG_ADDR;
            DataOut    <= CfgShadow ^ 8'h01;
            CpuWe_n    <= 1'b0;
            CpuClock_n <= 1'b1;
          end
        end
        REG_A: begin
          state      <= REG_B;
          CpuClock_n <= 1'b0;
        end
        REG_B: begin
          CfgShadow  <= DataOut;
          state      <= IDLE;
          CpuClock_n <= 1'b1;
          CpuWe_n    <= 1'b1;
          Busy       <= 1'b0;
          CmdReady   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_bus_writer.sv
// Directed bench for fb_bus_writer: bus writes are logged at each phase B and compared with hand-computed lists.
module tb_fb_bus_writer;

  logic        Clock;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [1:0]  CmdOp;
  logic [7:0]  CmdX;
  logic [6:0]  CmdY;
  logic [7:0]  CmdLen;
  logic [7:0]  CmdData;
  logic        VBlank;
  logic [15:0] AddrPhys;
  logic [7:0]  DataOut;
  logic        CpuWe_n;
  logic        CpuClock_n;
  logic        Busy;
  logic        Clipped;
  logic [7:0]  CfgShadow;

  fb_bus_writer dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdX(CmdX), .CmdY(CmdY), .CmdLen(CmdLen), .CmdData(CmdData),
    .VBlank(VBlank), .AddrPhys(AddrPhys), .DataOut(DataOut), .CpuWe_n(CpuWe_n),
    .CpuClock_n(CpuClock_n), .Busy(Busy), .Clipped(Clipped), .CfgShadow(CfgShadow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          clip_cnt = 0;

  always @(negedge Clock) begin
    if (!CpuClock_n && !CpuWe_n) begin
      wa.push_back(AddrPhys);
      wd.push_back(DataOut);
    end
    if (Clipped) clip_cnt++;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Holds the command until it is taken, then returns just after the accept edge.
  task automatic send(input logic [1:0] op, input logic [7:0] x, input logic [6:0] y,
                      input logic [7:0] len, input logic [7:0] dat);
    int n;
    CmdValid = 1'b1; CmdOp = op; CmdX = x; CmdY = y; CmdLen = len; CmdData = dat;
    n = 0;
    while (!CmdReady && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    CmdValid = 1'b0;
  endtask

  // Counts clocks spent busy from the current cycle, then settles one more cycle.
  task automatic run_idle(output int cycles);
    cycles = 0;
    while (Busy && cycles < 500) begin
      cycles++;
      tick();
    end
    if (cycles >= 500) chk("busy_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [15:0] a, input logic [7:0] d);
    chk({tag, "_addr"}, (idx < wa.size()) ? {16'h0, wa[idx]} : 32'hDEAD, {16'h0, a});
    chk({tag, "_data"}, (idx < wd.size()) ? {24'h0, wd[idx]} : 32'hDEAD, {24'h0, d});
  endtask

  initial begin
    int base;
    int cb;
    int cyc;
    Reset = 1'b1; CmdValid = 1'b0; CmdOp = 2'd0; CmdX = '0; CmdY = '0;
    CmdLen = '0; CmdData = '0; VBlank = 1'b0;
    tick(); tick();
    chk("rst_ready", {31'h0, CmdReady}, 32'd0);
    chk("rst_addr", {16'h0, AddrPhys}, 32'h0);
    chk("rst_data", {24'h0, DataOut}, 32'h0);
    chk("rst_we", {31'h0, CpuWe_n}, 32'd1);
    chk("rst_phi", {31'h0, CpuClock_n}, 32'd1);
    chk("rst_busy", {31'h0, Busy}, 32'd0);
    chk("rst_clip", {31'h0, Clipped}, 32'd0);
    chk("rst_shadow", {24'h0, CfgShadow}, 32'h0);
    Reset = 1'b0;
    tick();
    chk("ready_after_rst", {31'h0, CmdReady}, 32'd1);

    // Plain run, same bank: three pixels on row 5.
    base = wa.size(); cb = clip_cnt;
    send(2'd0, 8'd10, 7'd5, 8'd2, 8'h3C);
    chk("run1_phaseA_phi", {31'h0, CpuClock_n}, 32'd1);
    chk("run1_phaseA_we", {31'h0, CpuWe_n}, 32'd0);
    chk("run1_phaseA_addr", {16'h0, AddrPhys}, 32'h450A);
    tick();
    chk("run1_phaseB_phi", {31'h0, CpuClock_n}, 32'd0);
    chk("run1_phaseB_addr", {16'h0, AddrPhys}, 32'h450A);
    run_idle(cyc);
    chk("run1_cycles", cyc + 1, 32'd6);
    chk("run1_nwr", wa.size() - base, 32'd3);
    chk_wr("run1_w0", base, 16'h450A, 8'h3C);
    chk_wr("run1_w1", base + 1, 16'h450B, 8'h3C);
    chk_wr("run1_w2", base + 2, 16'h450C, 8'h3C);
    chk("run1_clip", clip_cnt - cb, 32'd0);
    chk("run1_idle_we", {31'h0, CpuWe_n}, 32'd1);

    // Bank switch plus right-edge clip.
    base = wa.size(); cb = clip_cnt;
    send(2'd0, 8'd158, 7'd70, 8'd5, 8'hFF);
    run_idle(cyc);
    chk("run2_cycles", cyc, 32'd6);
    chk("run2_nwr", wa.size() - base, 32'd3);
    chk_wr("run2_bank", base, 16'h40A0, 8'h02);
    chk_wr("run2_p0", base + 1, 16'h469E, 8'hFF);
    chk_wr("run2_p1", base + 2, 16'h469F, 8'hFF);
    chk("run2_clip", clip_cnt - cb, 32'd1);
    chk("run2_shadow", {24'h0, CfgShadow}, 32'h02);

    // Row out of range is dropped on the accept edge.
    base = wa.size(); cb = clip_cnt;
    send(2'd0, 8'd0, 7'd120, 8'd3, 8'h11);
    chk("drop_y_clip_now", {31'h0, Clipped}, 32'd1);
    chk("drop_y_ready", {31'h0, CmdReady}, 32'd1);
    chk("drop_y_busy", {31'h0, Busy}, 32'd0);
    tick();
    chk("drop_y_clip_off", {31'h0, Clipped}, 32'd0);
    // Column out of range and the reserved op.
    send(2'd0, 8'd160, 7'd0, 8'd0, 8'h22);
    tick();
    send(2'd3, 8'd0, 7'd0, 8'd0, 8'h33);
    chk("rsvd_busy", {31'h0, Busy}, 32'd0);
    tick(); tick();
    chk("drop_nwr", wa.size() - base, 32'd0);
    chk("drop_clip", clip_cnt - cb, 32'd2);

    // Last column exactly, bank already matches: one write, no clip.
    base = wa.size(); cb = clip_cnt;
    send(2'd0, 8'd159, 7'd64, 8'd0, 8'h5A);
    run_idle(cyc);
    chk("edge_nwr", wa.size() - base, 32'd1);
    chk_wr("edge_w0", base, 16'h409F, 8'h5A);
    chk("edge_clip", clip_cnt - cb, 32'd0);

    // X+Len overflows 8 bits: still clipped at the last column.
    base = wa.size(); cb = clip_cnt;
    send(2'd0, 8'd150, 7'd64, 8'd255, 8'h77);
    run_idle(cyc);
    chk("wrap_nwr", wa.size() - base, 32'd10);
    chk_wr("wrap_first", base, 16'h4096, 8'h77);
    chk_wr("wrap_last", base + 9, 16'h409F, 8'h77);
    chk("wrap_clip", clip_cnt - cb, 32'd1);

    // FLIP accepted while VBlank is already high must wait for the next rise.
    send(2'd1, 8'd0, 7'd0, 8'd0, 8'h00);
    run_idle(cyc);
    chk("cfg0_shadow", {24'h0, CfgShadow}, 32'h00);
    base = wa.size();
    VBlank = 1'b1;
    tick();
    send(2'd2, 8'd0, 7'd0, 8'd0, 8'h00);
    tick(); tick(); tick();
    chk("flip_wait_busy", {31'h0, Busy}, 32'd1);
    VBlank = 1'b0;
    tick(); tick();
    chk("flip_no_early_wr", wa.size() - base, 32'd0);
    VBlank = 1'b1;
    tick();
    run_idle(cyc);
    chk("flip_cycles", cyc, 32'd2);
    chk("flip_nwr", wa.size() - base, 32'd1);
    chk_wr("flip_w", base, 16'h40A0, 8'h01);
    chk("flip_shadow", {24'h0, CfgShadow}, 32'h01);

    // CFG immediately followed by FLIP.
    VBlank = 1'b0;
    tick(); tick();
    base = wa.size();
    send(2'd1, 8'd0, 7'd0, 8'd0, 8'h1C);
    send(2'd2, 8'd0, 7'd0, 8'd0, 8'h00);
    chk("cfgflip_shadow_mid", {24'h0, CfgShadow}, 32'h1C);
    chk("cfgflip_waiting", {31'h0, Busy}, 32'd1);
    VBlank = 1'b1;
    tick();
    run_idle(cyc);
    chk("cfgflip_nwr", wa.size() - base, 32'd2);
    chk_wr("cfgflip_w0", base, 16'h40A0, 8'h1C);
    chk_wr("cfgflip_w1", base + 1, 16'h40A0, 8'h1D);
    chk("cfgflip_shadow", {24'h0, CfgShadow}, 32'h1D);
    VBlank = 1'b0;

    // Reset during the second pixel's phase B of a 10-pixel run.
    send(2'd0, 8'd0, 7'd0, 8'd9, 8'h44);
    tick(); tick(); tick();
    chk("abort_in_phaseB", {31'h0, CpuClock_n}, 32'd0);
    Reset = 1'b1;
    tick();
    chk("abort_phi", {31'h0, CpuClock_n}, 32'd1);
    chk("abort_we", {31'h0, CpuWe_n}, 32'd1);
    chk("abort_shadow", {24'h0, CfgShadow}, 32'h00);
    chk("abort_busy", {31'h0, Busy}, 32'd0);
    Reset = 1'b0;
    base = wa.size();
    for (int i = 0; i < 30; i++) tick();
    chk("abort_no_resume", wa.size() - base, 32'd0);
    chk("abort_ready", {31'h0, CmdReady}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
